// File: rtl/hazard_control_unit_pkg.sv
// Shared constants for the 5-stage pipeline hazard controller:
// forwarding-select encodings, the PC register number and FSM states.
package hazard_control_unit_pkg;

    // Operand source selects for the ID-stage forwarding muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // R15 is the PC; it is never forwarded and never causes a load-use stall
    localparam logic [3:0] R_PC = 4'd15;

    // Sequencing FSM states
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_LU_STALL = 1'b1;

    // Width of the load-bubble down-counter (LOAD_BUBBLES is at most 7)
    localparam int BUB_W = 3;

endpackage

// File: rtl/hazard_control_unit_forwarding_select.sv
// Combinational forwarding priority selector for one ID-stage source
// operand. EX beats MEM beats WB; a load in EX cannot forward because its
// data is not available until MEM.
module forwarding_select
    import hazard_control_unit_pkg::*;
(
    input  logic [3:0] src,
    input  logic       use_src,
    input  logic [3:0] ex_rd,
    input  logic       ex_rf_enable,
    input  logic       ex_load_instr,
    input  logic [3:0] mem_rd,
    input  logic       mem_rf_enable,
    input  logic [3:0] wb_rd,
    input  logic       wb_rf_enable,
    output logic [1:0] sel
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = ex_rf_enable  && !ex_load_instr && (ex_rd  == src);
    assign mem_hit = mem_rf_enable && (mem_rd == src);
    assign wb_hit  = wb_rf_enable  && (wb_rd  == src);

    // Priority pick of the youngest producer; unused operands and R15 read the RF
    always_comb begin
        sel = FWD_RF;
        if (use_src && (src != R_PC)) begin
            if (ex_hit)
                sel = FWD_EX;
            else if (mem_hit)
                sel = FWD_MEM;
            else if (wb_hit)
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls (LOAD_BUBBLES cycles),
// taken-branch IF/ID flushes, operand forwarding selects and saturating
// stall/flush event counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [3:0]       ID_RA,
    input  logic [3:0]       ID_RB,
    input  logic [3:0]       ID_RD,
    input  logic             ID_use_A,
    input  logic             ID_use_B,
    input  logic             ID_use_D,
    input  logic [3:0]       EX_RD,
    input  logic             EX_RF_enable,
    input  logic             EX_load_instr,
    input  logic [3:0]       MEM_RD,
    input  logic             MEM_RF_enable,
    input  logic [3:0]       WB_RD,
    input  logic             WB_RF_enable,
    input  logic             branch_taken,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             CU_MUX_E,
    output logic             IF_ID_flush,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       fwd_D,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Remaining bubbles after the first stall cycle taken in RUN
    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_BUBBLES - 1);
    localparam logic [BUB_W-1:0] BUB_ONE  = BUB_W'(1);

    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic [BUB_W-1:0] bub;
    logic [BUB_W-1:0] bub_nx;
    logic             lu;
    logic             stall;
    logic             flush;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic [1:0]       sel_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // ---------------------------------------------------------------
    // Forwarding selects, one priority selector per source operand
    // ---------------------------------------------------------------
    forwarding_select u_fwd_a (
        .src           (ID_RA),
        .use_src       (ID_use_A),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_enable),
        .ex_load_instr (EX_load_instr),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_enable),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_enable),
        .sel           (sel_a)
    );

    forwarding_select u_fwd_b (
        .src           (ID_RB),
        .use_src       (ID_use_B),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_enable),
        .ex_load_instr (EX_load_instr),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_enable),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_enable),
        .sel           (sel_b)
    );

    forwarding_select u_fwd_d (
        .src           (ID_RD),
        .use_src       (ID_use_D),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_enable),
        .ex_load_instr (EX_load_instr),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_enable),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_enable),
        .sel           (sel_d)
    );

    // ---------------------------------------------------------------
    // Load-use detection: a load in EX whose destination is read in ID.
    // The R15 exclusion on EX_RD also covers the sources, since a match
    // requires equality.
    // ---------------------------------------------------------------
    assign lu = EX_load_instr && EX_RF_enable && (EX_RD != R_PC) &&
                ((ID_use_A && (ID_RA == EX_RD)) ||
                 (ID_use_B && (ID_RB == EX_RD)) ||
                 (ID_use_D && (ID_RD == EX_RD)));

    // Next-state and same-cycle stall/flush decode; a stall always masks a branch
    always_comb begin
        state_nx = state;
        bub_nx   = bub;
        stall    = 1'b0;
        flush    = 1'b0;
        case (state)
            ST_RUN: begin
                if (lu) begin
                    stall = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_nx = ST_LU_STALL;
                        bub_nx   = BUB_INIT;
                    end
                end else if (branch_taken) begin
                    flush = 1'b1;
                end
            end
            ST_LU_STALL: begin
                stall = 1'b1;
                if (bub == BUB_ONE) begin
                    state_nx = ST_RUN;
                    bub_nx   = '0;
                end else begin
                    bub_nx = bub - BUB_ONE;
                end
            end
            default: begin
                state_nx = ST_RUN;
                bub_nx   = '0;
            end
        endcase
        // Reset presents a free-running pipeline regardless of inputs
        if (Clr) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    // FSM state and bubble counter
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= ST_RUN;
            bub   <= '0;
        end else begin
            state <= state_nx;
            bub   <= bub_nx;
        end
    end

    // Saturating event counters; they hold at all-ones instead of wrapping
    always_ff @(posedge Clk) begin
        if (Clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
            if (flush && (flush_q != {CNT_W{1'b1}}))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign PC_LE       = !stall;
    assign IF_ID_LE    = !stall;
    assign CU_MUX_E    = stall;
    assign IF_ID_flush = flush;
    assign fwd_A       = Clr ? FWD_RF : sel_a;
    assign fwd_B       = Clr ? FWD_RF : sel_b;
    assign fwd_D       = Clr ? FWD_RF : sel_d;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Three instances share stimulus:
// LOAD_BUBBLES=1, LOAD_BUBBLES=3, and a 2-bit-counter copy for saturation.
module tb_hazard_control_unit;

    logic       Clk = 1'b0;
    logic       Clr;
    logic [3:0] ID_RA, ID_RB, ID_RD, EX_RD, MEM_RD, WB_RD;
    logic       ID_use_A, ID_use_B, ID_use_D;
    logic       EX_RF_enable, EX_load_instr, MEM_RF_enable, WB_RF_enable;
    logic       branch_taken;

    logic        pc1, ifid1, cu1, fl1;
    logic [1:0]  fa1, fb1, fd1;
    logic [15:0] sc1, fc1;
    logic        pc3, ifid3, cu3, fl3;
    logic [1:0]  fa3, fb3, fd3;
    logic [15:0] sc3, fc3;
    logic        pcs, ifids, cus, fls;
    logic [1:0]  fas, fbs, fds;
    logic [1:0]  scs, fcs;

    int pass_cnt = 0;
    int total    = 0;

    always #5 Clk = ~Clk;

    hazard_control_unit #(.LOAD_BUBBLES(1), .CNT_W(16)) u_lb1 (
        .Clk(Clk), .Clr(Clr), .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_RD(ID_RD),
        .ID_use_A(ID_use_A), .ID_use_B(ID_use_B), .ID_use_D(ID_use_D),
        .EX_RD(EX_RD), .EX_RF_enable(EX_RF_enable), .EX_load_instr(EX_load_instr),
        .MEM_RD(MEM_RD), .MEM_RF_enable(MEM_RF_enable), .WB_RD(WB_RD),
        .WB_RF_enable(WB_RF_enable), .branch_taken(branch_taken),
        .PC_LE(pc1), .IF_ID_LE(ifid1), .CU_MUX_E(cu1), .IF_ID_flush(fl1),
        .fwd_A(fa1), .fwd_B(fb1), .fwd_D(fd1), .stall_count(sc1), .flush_count(fc1)
    );

    hazard_control_unit #(.LOAD_BUBBLES(3), .CNT_W(16)) u_lb3 (
        .Clk(Clk), .Clr(Clr), .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_RD(ID_RD),
        .ID_use_A(ID_use_A), .ID_use_B(ID_use_B), .ID_use_D(ID_use_D),
        .EX_RD(EX_RD), .EX_RF_enable(EX_RF_enable), .EX_load_instr(EX_load_instr),
        .MEM_RD(MEM_RD), .MEM_RF_enable(MEM_RF_enable), .WB_RD(WB_RD),
        .WB_RF_enable(WB_RF_enable), .branch_taken(branch_taken),
        .PC_LE(pc3), .IF_ID_LE(ifid3), .CU_MUX_E(cu3), .IF_ID_flush(fl3),
        .fwd_A(fa3), .fwd_B(fb3), .fwd_D(fd3), .stall_count(sc3), .flush_count(fc3)
    );

    hazard_control_unit #(.LOAD_BUBBLES(1), .CNT_W(2)) u_sat (
        .Clk(Clk), .Clr(Clr), .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_RD(ID_RD),
        .ID_use_A(ID_use_A), .ID_use_B(ID_use_B), .ID_use_D(ID_use_D),
        .EX_RD(EX_RD), .EX_RF_enable(EX_RF_enable), .EX_load_instr(EX_load_instr),
        .MEM_RD(MEM_RD), .MEM_RF_enable(MEM_RF_enable), .WB_RD(WB_RD),
        .WB_RF_enable(WB_RF_enable), .branch_taken(branch_taken),
        .PC_LE(pcs), .IF_ID_LE(ifids), .CU_MUX_E(cus), .IF_ID_flush(fls),
        .fwd_A(fas), .fwd_B(fbs), .fwd_D(fds), .stall_count(scs), .flush_count(fcs)
    );

    task automatic quiet();
        ID_RA = 4'd0; ID_RB = 4'd0; ID_RD = 4'd0;
        ID_use_A = 1'b0; ID_use_B = 1'b0; ID_use_D = 1'b0;
        EX_RD = 4'd0; EX_RF_enable = 1'b0; EX_load_instr = 1'b0;
        MEM_RD = 4'd0; MEM_RF_enable = 1'b0;
        WB_RD = 4'd0; WB_RF_enable = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Two clocked cycles of Clr, released on a falling edge
    task automatic do_reset();
        @(negedge Clk);
        quiet();
        Clr = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Clr = 1'b0;
    endtask

    // Load to R5 in EX, ID reads R5 through operand B
    task automatic set_hazard();
        quiet();
        EX_RD = 4'd5; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_RB = 4'd5; ID_use_B = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (pc1 !== 1'b1) $display("FAIL reset_pc_le: got %0b expected 1", pc1); else pass_cnt++;
        total++; if (ifid1 !== 1'b1) $display("FAIL reset_if_id_le: got %0b expected 1", ifid1); else pass_cnt++;
        total++; if (cu1 !== 1'b0) $display("FAIL reset_cu_mux_e: got %0b expected 0", cu1); else pass_cnt++;
        total++; if (fl1 !== 1'b0) $display("FAIL reset_flush: got %0b expected 0", fl1); else pass_cnt++;
        total++; if ({fa1, fb1, fd1} !== 6'b0) $display("FAIL reset_fwd: got %0h expected 0", {fa1, fb1, fd1}); else pass_cnt++;
        total++; if (sc1 !== 16'd0 || fc1 !== 16'd0) $display("FAIL reset_counts: got %0h/%0h expected 0/0", sc1, fc1); else pass_cnt++;
        total++; if (cu3 !== 1'b0 || sc3 !== 16'd0) $display("FAIL reset_lb3: got cu=%0b sc=%0h expected 0/0", cu3, sc3); else pass_cnt++;
    endtask

    task automatic test_forwarding();
        @(negedge Clk);
        quiet();
        EX_RD = 4'd3; EX_RF_enable = 1'b1; MEM_RD = 4'd3; MEM_RF_enable = 1'b1;
        ID_RA = 4'd3; ID_use_A = 1'b1;
        #1;
        total++; if (fa1 !== 2'b01) $display("FAIL fwd_ex_over_mem: got %0b expected 01", fa1); else pass_cnt++;
        total++; if (fb1 !== 2'b00) $display("FAIL fwd_unused_b: got %0b expected 00", fb1); else pass_cnt++;
        @(negedge Clk);
        EX_RF_enable = 1'b0;
        #1;
        total++; if (fa1 !== 2'b10) $display("FAIL fwd_mem: got %0b expected 10", fa1); else pass_cnt++;
        @(negedge Clk);
        MEM_RF_enable = 1'b0; WB_RD = 4'd3; WB_RF_enable = 1'b1;
        #1;
        total++; if (fa1 !== 2'b11) $display("FAIL fwd_wb: got %0b expected 11", fa1); else pass_cnt++;
        @(negedge Clk);
        ID_RA = 4'd15; EX_RD = 4'd15; EX_RF_enable = 1'b1;
        MEM_RD = 4'd15; MEM_RF_enable = 1'b1; WB_RD = 4'd15;
        #1;
        total++; if (fa1 !== 2'b00) $display("FAIL fwd_r15: got %0b expected 00", fa1); else pass_cnt++;
        @(negedge Clk);
        quiet();
        EX_RD = 4'd3; EX_RF_enable = 1'b1; ID_RA = 4'd3; ID_use_A = 1'b0;
        ID_RB = 4'd3; ID_use_B = 1'b1; ID_RD = 4'd3; ID_use_D = 1'b1;
        #1;
        total++; if (fa1 !== 2'b00) $display("FAIL fwd_use_a_off: got %0b expected 00", fa1); else pass_cnt++;
        total++; if (fb1 !== 2'b01 || fd1 !== 2'b01) $display("FAIL fwd_b_d_ex: got %0b/%0b expected 01/01", fb1, fd1); else pass_cnt++;
        @(negedge Clk);
        quiet();
        EX_RD = 4'd7; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        MEM_RD = 4'd7; MEM_RF_enable = 1'b1; ID_RB = 4'd7; ID_use_B = 1'b1;
        #1;
        total++; if (fb1 !== 2'b10) $display("FAIL fwd_load_in_ex: got %0b expected 10", fb1); else pass_cnt++;
        total++; if (cu1 !== 1'b1) $display("FAIL fwd_load_stall: got %0b expected 1", cu1); else pass_cnt++;
    endtask

    task automatic test_lu_single();
        do_reset();
        set_hazard();
        #1;
        total++; if ({pc1, ifid1, cu1} !== 3'b001) $display("FAIL lu1_stall: got %0b expected 001", {pc1, ifid1, cu1}); else pass_cnt++;
        @(negedge Clk);
        quiet();
        MEM_RD = 4'd5; MEM_RF_enable = 1'b1; ID_RB = 4'd5; ID_use_B = 1'b1;
        #1;
        total++; if (fb1 !== 2'b10) $display("FAIL lu1_fwd_mem: got %0b expected 10", fb1); else pass_cnt++;
        total++; if ({pc1, ifid1, cu1} !== 3'b110) $display("FAIL lu1_released: got %0b expected 110", {pc1, ifid1, cu1}); else pass_cnt++;
        total++; if (sc1 !== 16'd1) $display("FAIL lu1_stall_count: got %0d expected 1", sc1); else pass_cnt++;
    endtask

    task automatic test_lu_multi();
        do_reset();
        set_hazard();
        #1;
        total++; if ({pc3, ifid3, cu3} !== 3'b001) $display("FAIL lu3_cycle1: got %0b expected 001", {pc3, ifid3, cu3}); else pass_cnt++;
        for (int c = 2; c <= 3; c++) begin
            @(negedge Clk);
            quiet();
            branch_taken = 1'b1;
            #1;
            total++; if ({pc3, ifid3, cu3, fl3} !== 4'b0010) $display("FAIL lu3_cycle%0d: got %0b expected 0010", c, {pc3, ifid3, cu3, fl3}); else pass_cnt++;
        end
        @(negedge Clk);
        quiet();
        #1;
        total++; if ({pc3, cu3} !== 2'b10) $display("FAIL lu3_released: got %0b expected 10", {pc3, cu3}); else pass_cnt++;
        total++; if (sc3 !== 16'd3 || fc3 !== 16'd0) $display("FAIL lu3_counts: got %0d/%0d expected 3/0", sc3, fc3); else pass_cnt++;
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1;
        #1;
        total++; if ({fl1, pc1, ifid1, cu1} !== 4'b1110) $display("FAIL br_flush: got %0b expected 1110", {fl1, pc1, ifid1, cu1}); else pass_cnt++;
        @(negedge Clk);
        branch_taken = 1'b0;
        #1;
        total++; if (fl1 !== 1'b0 || fc1 !== 16'd1) $display("FAIL br_after: got fl=%0b fc=%0d expected 0/1", fl1, fc1); else pass_cnt++;
        @(negedge Clk);
        set_hazard();
        branch_taken = 1'b1;
        #1;
        total++; if ({cu1, fl1} !== 2'b10) $display("FAIL br_lu_both: got %0b expected 10", {cu1, fl1}); else pass_cnt++;
        @(negedge Clk);
        quiet();
        #1;
        total++; if (fc1 !== 16'd1 || sc1 !== 16'd1) $display("FAIL br_lu_counts: got fc=%0d sc=%0d expected 1/1", fc1, sc1); else pass_cnt++;
    endtask

    task automatic test_clr_mid_stall();
        do_reset();
        set_hazard();
        @(negedge Clk);
        quiet();
        #1;
        total++; if (cu3 !== 1'b1) $display("FAIL clr_pre_stall: got %0b expected 1", cu3); else pass_cnt++;
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        total++; if ({pc3, cu3} !== 2'b10) $display("FAIL clr_mid_outputs: got %0b expected 10", {pc3, cu3}); else pass_cnt++;
        total++; if (sc3 !== 16'd0 || fc3 !== 16'd0) $display("FAIL clr_mid_counts: got %0d/%0d expected 0/0", sc3, fc3); else pass_cnt++;
        @(negedge Clk);
        #1;
        total++; if (cu3 !== 1'b0) $display("FAIL clr_mid_no_resume: got %0b expected 0", cu3); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_hazard();
        @(negedge Clk);
        @(negedge Clk);
        #1;
        total++; if (scs !== 2'd2) $display("FAIL sat_two: got %0d expected 2", scs); else pass_cnt++;
        @(negedge Clk);
        #1;
        total++; if (scs !== 2'd3) $display("FAIL sat_full: got %0d expected 3", scs); else pass_cnt++;
        total++; if (cus !== 1'b1) $display("FAIL sat_still_stalls: got %0b expected 1", cus); else pass_cnt++;
        @(negedge Clk);
        #1;
        total++; if (scs !== 2'd3) $display("FAIL sat_hold: got %0d expected 3", scs); else pass_cnt++;
        quiet();
    endtask

    initial begin
        Clr = 1'b1;
        quiet();
        test_reset();
        test_forwarding();
        test_lu_single();
        test_lu_multi();
        test_branch();
        test_clr_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives the PC and IF/ID load enables, the control-unit NOP mux select and the IF/ID flush.
- Generates operand-forwarding selects for the ID-stage register operands.
- Runs a small FSM for load-use stalls (multi-cycle, configurable) and taken-branch flushes, and keeps saturating stall/flush event counters.

Parameters:
LOAD_BUBBLES, 1, stall cycles inserted per load-use hazard (legal 1..7)
CNT_W, 16, width of stall/flush event counters

Ports:
Clk  input  1  pipeline clock, rising edge
Clr  input  1  synchronous active-high reset
ID_RA  input  4  ID source register A (I19_16)
ID_RB  input  4  ID source register B (I3_0)
ID_RD  input  4  ID store-data source register (I15_12)
ID_use_A  input  1  instruction in ID reads RA
ID_use_B  input  1  instruction in ID reads RB
ID_use_D  input  1  instruction in ID reads RD as store data
EX_RD  input  4  destination register in EX
EX_RF_enable  input  1  EX writes the register file
EX_load_instr  input  1  EX holds a load
MEM_RD  input  4  destination register in MEM
MEM_RF_enable  input  1  MEM writes the register file
WB_RD  input  4  destination register in WB
WB_RF_enable  input  1  WB writes the register file
branch_taken  input  1  ID condition handler: B/BL taken this cycle
PC_LE  output  1  PC load enable (1 = advance)
IF_ID_LE  output  1  IF/ID load enable
CU_MUX_E  output  1  1 = control-unit mux selects all-zero NOP into ID/EX
IF_ID_flush  output  1  1 = IF/ID loads a NOP at the next edge
fwd_A  output  2  00 RF, 01 EX, 10 MEM, 11 WB
fwd_B  output  2  same encoding
fwd_D  output  2  same encoding
stall_count  output  CNT_W  stall cycles since reset, saturating
flush_count  output  CNT_W  flushes since reset, saturating

Behaviour:
- Clock and reset: single clock Clk; Clr is synchronous, active-high.
- While Clr = 1: state = RUN, bubble counter = 0, stall_count = 0, flush_count = 0.
- Outputs during and after reset: PC_LE = 1, IF_ID_LE = 1, CU_MUX_E = 0, IF_ID_flush = 0, fwd_* = 00.
- Forwarding (combinational, every state):
  - Per source X, only when ID_use_X = 1 and the source register is not R15.
  - Priority: EX match (EX_RF_enable, EX_RD == src, not EX_load_instr) -> 01; else MEM match -> 10; else WB match -> 11; else 00.
  - A source whose ID_use bit is 0 gets 00.
- Load-use hazard (combinational): lu = EX_load_instr & EX_RF_enable & EX_RD != 15 & (any used source == EX_RD).
- FSM states:
  - RUN:
    - If lu: assert stall this cycle (PC_LE = 0, IF_ID_LE = 0, CU_MUX_E = 1).
    - If LOAD_BUBBLES > 1, go to LU_STALL with counter = LOAD_BUBBLES - 1; otherwise stay in RUN.
    - Else if branch_taken: IF_ID_flush = 1, PC_LE = 1, go to RUN (single-cycle flush, no extra state).
  - LU_STALL:
    - Stall outputs asserted unconditionally and branch_taken ignored.
    - Counter decrements each cycle; on counter == 1, return to RUN next edge.
- Priority: an active stall masks branch_taken. The branch remains in ID and is re-evaluated after the stall.
- Simultaneous lu and branch_taken: stall wins, no flush, flush_count unchanged.
- Counters:
  - stall_count += 1 on each cycle with CU_MUX_E = 1 due to a stall.
  - flush_count += 1 on each cycle with IF_ID_flush = 1.
  - Both saturate at all-ones, with no wrap.
- Clr mid-stall: next cycle state = RUN, all stall outputs deasserted.
- Latency: stall/flush outputs are same-cycle combinational from inputs and state. State and counters update on the rising edge.

Decomposition:
- Shared package constants: FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10, FWD_WB = 2'b11, R_PC = 4'd15.
- Shared package also holds the FSM state encodings: RUN, LU_STALL.
- One natural sub-module: forwarding_select, combinational priority selector instantiated three times (A, B, D).

Test Plan:
- Clr = 1 for 2 cycles, then release -> PC_LE = 1, IF_ID_LE = 1, CU_MUX_E = 0, fwd_* = 00, counters = 0.
- EX_RD = 3, EX_RF_enable = 1, not load; ID_RA = 3, ID_use_A = 1; MEM_RD = 3 also valid -> fwd_A = 01 (EX beats MEM). With EX_RF_enable = 0 -> fwd_A = 10. With ID_RA = 15 -> fwd_A = 00.
- Load in EX (EX_RD = 5), ID_RB = 5, ID_use_B = 1, LOAD_BUBBLES = 1 -> one cycle with PC_LE = 0, IF_ID_LE = 0, CU_MUX_E = 1; next cycle with load in MEM -> fwd_B = 10, no stall; stall_count = 1.
- LOAD_BUBBLES = 3, same hazard -> exactly 3 stall cycles; branch_taken = 1 during stall -> no flush; stall_count = 3, flush_count = 0.
- branch_taken = 1 for one cycle with no hazard -> IF_ID_flush = 1, PC_LE = 1, flush_count = 1. Simultaneous lu and branch_taken -> stall only.
- Clr asserted in the 2nd cycle of a 3-bubble stall -> next cycle PC_LE = 1, CU_MUX_E = 0, counters = 0. Force stall_count to 16'hFFFF plus one more stall -> stays at 16'hFFFF.
